square_build: RTL and testbench

Sequential shift-add squarer that runs the integer square root in the opposite direction. From an N/2-bit root and, optionally, an (N/2+1)-bit remainder, it rebuilds the N-bit number root² + rem. It sits downstream of the iterative square-root unit, with a matching start/done handshake, and is used as the round-trip checker and number reconstructor in the arithmetic datapath. One product bit is processed per clock, so a result takes N/2 cycles.

---
 rtl/square_build.sv | 108 ++++++++++
 tb/tb_square_build.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/square_build.sv
// square_build: shift-add squarer, rebuilds root^2 (+ rem) one bit per clock.
// Optional remainder preload and range flag under `define SQUARE_REM_EN.
module square_build #(
  parameter int N = 32
) (
  input  logic           Clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [N/2-1:0] root_in,
  input  logic [N/2:0]   rem_in,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   square_out,
  output logic           rem_err
);

  localparam int H  = N / 2;
  localparam int KW = ($clog2(H) < 4) ? 4 : $clog2(H);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CALC = 1'b1;

  localparam logic [KW-1:0] K_LAST = KW'(H - 1);

  logic [0:0]    state;
  logic [N-1:0]  acc;
  logic [N-1:0]  mcand;
  logic [H-1:0]  mplier;
  logic [KW-1:0] k;
  logic          err_cap;

  logic [N-1:0]  acc_init;
  logic          rem_flag;
  logic [N-1:0]  acc_add;
  logic [N-1:0]  acc_nxt;

`ifdef SQUARE_REM_EN
  logic [H+1:0] rem_x;
  logic [H+1:0] root_x2;

  // Remainder preload and out-of-range flag from the operands
  always_comb begin
    rem_x    = {1'b0, rem_in};
    root_x2  = {1'b0, root_in, 1'b0};
    rem_flag = rem_x > root_x2;
    acc_init = N'(rem_in);
  end
`else
  logic unused_rem;

  // Remainder is ignored: accumulator starts from zero, no flag
  always_comb begin
    unused_rem = ^rem_in;
    rem_flag   = 1'b0;
    acc_init   = '0;
  end
`endif

  // Conditional add of the shifted multiplicand, wraps mod 2^N
  always_comb begin
    acc_add = acc + mcand;
    acc_nxt = mplier[0] ? acc_add : acc;
  end

  assign busy = (state == S_CALC);

  // Capture on start, then one multiplier bit per clock
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      k          <= '0;
      err_cap    <= 1'b0;
      done       <= 1'b0;
      square_out <= '0;
      rem_err    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mcand   <= N'(root_in);
            mplier  <= root_in;
            acc     <= acc_init;
            k       <= '0;
            err_cap <= rem_flag;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          k      <= k + KW'(1);
          if (k == K_LAST) begin
            square_out <= acc_nxt;
            done       <= 1'b1;
            rem_err    <= err_cap;
            state      <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square_build.sv
// tb_square_build: randomized check of square_build (N=16)
// against an arithmetic reference model.
module tb_square_build;

  localparam int N = 16;
  localparam int H = N / 2;

`ifdef SQUARE_REM_EN
  localparam bit REM = 1'b1;
`else
  localparam bit REM = 1'b0;
`endif

  logic         Clock;
  logic         reset_n;
  logic         start;
  logic [H-1:0] root_in;
  logic [H:0]   rem_in;
  logic         busy;
  logic         done;
  logic [N-1:0] square_out;
  logic         rem_err;

  int n_cmp;
  int n_bad;

  square_build #(.N(N)) dut (
    .Clock      (Clock),
    .reset_n    (reset_n),
    .start      (start),
    .root_in    (root_in),
    .rem_in     (rem_in),
    .busy       (busy),
    .done       (done),
    .square_out (square_out),
    .rem_err    (rem_err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_sq(input int unsigned r,
                                           input int unsigned m);
    longint unsigned s;
    s = longint'(r) * longint'(r) + (REM ? longint'(m) : 0);
    return 32'(s % (64'd1 << N));
  endfunction

  function automatic logic [31:0] model_err(input int unsigned r,
                                            input int unsigned m);
    return {31'd0, REM && (m > 2 * r)};
  endfunction

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(posedge Clock); #1;
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  // start high at the next edge (E0); optional extra start at E0+poke
  task automatic do_op(input int unsigned r, input int unsigned m,
                       input int poke);
    logic [31:0] exp_sq;
    logic [31:0] exp_err;
    exp_sq  = model_sq(r, m);
    exp_err = model_err(r, m);
    root_in = r[H-1:0];
    rem_in  = m[H:0];
    start   = 1'b1;
    @(posedge Clock); #1;
    start   = 1'b0;
    root_in = H'($urandom);
    rem_in  = (H+1)'($urandom);
    chk("busy_e0", busy, 1);
    chk("done_e0", done, 0);
    for (int i = 1; i <= H; i++) begin
      start = (i == poke);
      @(posedge Clock); #1;
      start = 1'b0;
      if (i == H - 1) begin
        chk("done_early", done, 0);
        chk("busy_mid", busy, 1);
      end
    end
    chk("done", done, 1);
    chk("square", square_out, exp_sq);
    chk("rem_err", rem_err, exp_err);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    int unsigned r;
    int unsigned m;
    int unsigned num;
    int          saw;
    n_cmp   = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    root_in = '0;
    rem_in  = '0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sq", square_out, 0);
    chk("rst_err", rem_err, 0);
    @(negedge Clock);
    reset_n = 1'b1;

    // first edge after reset accepts
    do_op(255, 0, 0);
    chk("sq_255", square_out, 65025);
    idle(1);
    do_op(255, 510, 0);
    idle(1);
    do_op(12, 25, 0);
    chk("sq_12", square_out, REM ? 169 : 144);
    chk("err_12", rem_err, REM ? 1 : 0);
    idle(1);
    do_op(0, 0, 0);
    chk("sq_0", square_out, 0);

    // start mid-calc and at the final edge are ignored
    idle(1);
    do_op(100, 7, 3);
    idle(2);
    do_op(201, 400, H);
    idle(2);

    // back-to-back: start at E0+H+1 accepted
    do_op(17, 3, 0);
    do_op(250, 499, 0);
    do_op(3, 200, 0);
    idle(1);

    // reset in the middle of a calculation
    root_in = 200;
    rem_in  = 3;
    start   = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    repeat (5) @(posedge Clock);
    #1;
    chk("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sq", square_out, 0);
    chk("arst_err", rem_err, 0);
    @(negedge Clock);
    reset_n = 1'b1;
    saw = 0;
    repeat (H + 3) begin
      @(posedge Clock); #1;
      if (done) saw++;
    end
    chk("no_done_after_rst", saw, 0);
    chk("idle_after_rst", busy, 0);

    // random operands, random gaps and stray starts
    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, (1 << H) - 1);
      if ($urandom_range(0, 1) == 0)
        m = $urandom_range(0, 2 * r);
      else
        m = $urandom_range(0, (1 << (H + 1)) - 1);
      do_op(r, m, $urandom_range(0, H + 1));
      if ($urandom_range(0, 2) != 0)
        idle($urandom_range(1, 2));
    end

    // round trip from square-root results
    for (int t = 0; t < 300; t++) begin
      num = $urandom_range(1, (1 << N) - 1);
      r = 0;
      while ((r + 1) * (r + 1) <= num) r++;
      m = num - r * r;
      do_op(r, m, 0);
      if (REM) begin
        chk("rt_num", square_out, num);
        chk("rt_err", rem_err, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
